bcd_seg7_display: RTL and testbench

Parametrised numeric display driver for the DE-board seven-segment bank. It accepts a BIN_WIDTH-bit unsigned value on a start strobe and shows it on DIGITS active-low seven-segment digits, as decimal or hexadecimal. Decimal conversion is a sequential shift-and-add-3 (double dabble), one bit per clock. It sits between the datapath (counters, ALU results) and the HEX pins. It generalises the single-digit, combinational switch-to-HEX0 decoder with these additions:

- width and digit count
- a decimal mode
- leading-zero blanking
- a start/busy/done handshake

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/hex_to_seg7.sv | 32 +++
 rtl/bcd_seg7_display.sv | 142 ++++++++++++++
 tb/tb_bcd_seg7_display.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants (active-low, {g,f,e,d,c,b,a}) and the display FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit to active-low seven-segment decoder, zero latency.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_seg7_display.sv
// Multi-digit seven-segment driver: decimal via one-bit-per-clock double dabble, or hex.
// Decimal result lands BIN_WIDTH+1 clocks after start, hex after 1; starts while busy are dropped.
module bcd_seg7_display
  import seg7_pkg::*;
#(
  parameter int BIN_WIDTH     = 16,
  parameter int DIGITS        = 5,
  parameter bit BLANK_LEADING = 1'b1,
  parameter bit ALLOW_TRUNC   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [DIGITS*7-1:0]   HEX
);

  localparam int DW = DIGITS * 4;
  localparam int EW = (DW > BIN_WIDTH) ? DW : BIN_WIDTH;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  if (BIN_WIDTH < 4) begin : g_bad_width
    $error("bcd_seg7_display: BIN_WIDTH must be at least 4");
  end
  // Overflow is only reachable with fewer digits than the value needs; ALLOW_TRUNC permits that for hex-only use.
  if (!ALLOW_TRUNC && (pow10(DIGITS) <= ((longint'(1) << BIN_WIDTH) - 1))) begin : g_bad_digits
    $error("bcd_seg7_display: DIGITS too small for BIN_WIDTH");
  end

  state_t                    state_q, state_d;
  logic [BIN_WIDTH-1:0]      shift_q, shift_d;
  logic [DW-1:0]             bcd_q, bcd_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      mode_q, mode_d;
  logic [DIGITS*7-1:0]       hex_q, hex_d;
  logic                      done_q, done_d;
  logic                      ovf_q, ovf_d;

  logic [DW-1:0]             bcd_adj;
  logic [EW-1:0]             val_ext;
  logic                      hex_ovf;
  logic [DIGITS-1:0][3:0]    nib;
  logic [DIGITS-1:0][6:0]    seg_raw;
  logic [DIGITS*7-1:0]       seg_disp;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    assign bcd_adj[4*g +: 4] = (bcd_q[4*g +: 4] >= 4'd5) ? bcd_q[4*g +: 4] + 4'd3 : bcd_q[4*g +: 4];
  end

  // In hex mode the shift register is never shifted, so it still holds the captured value.
  assign val_ext = EW'(shift_q);

  if (EW > DW) begin : g_ovf
    assign hex_ovf = |val_ext[EW-1:DW];
  end else begin : g_no_ovf
    assign hex_ovf = 1'b0;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    assign nib[g] = mode_q ? val_ext[4*g +: 4] : bcd_q[4*g +: 4];
    hex_to_seg7 u_dec (
      .nib_i (nib[g]),
      .seg_o (seg_raw[g])
    );
  end

  always_comb begin
    logic lead_zero;
    lead_zero = 1'b1;
    seg_disp  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead_zero = lead_zero && (nib[i] == 4'd0);
      seg_disp[7*i +: 7] = (BLANK_LEADING && (i > 0) && lead_zero) ? SEG_BLANK : seg_raw[i];
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    hex_d   = hex_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = bin_in;
          mode_d  = mode;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = mode ? LOAD : CONV;
        end
      end
      CONV: begin
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BIN_WIDTH - 1)) state_d = LOAD;
      end
      LOAD: begin
        hex_d   = seg_disp;
        ovf_d   = mode_q & hex_ovf;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      hex_q   <= '1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      hex_q   <= hex_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign HEX      = hex_q;

endmodule

// File: tb/tb_bcd_seg7_display.sv
// Directed bench: main 16-bit/5-digit instance, a no-blanking twin and a 2-digit hex overflow instance.
module tb_bcd_seg7_display;

  logic        clk = 1'b0;
  logic        reset, start, mode;
  logic [15:0] bin_in;

  logic        busy_m, done_m, ovf_m;
  logic [34:0] hex_m;
  logic        busy_nb, done_nb, ovf_nb;
  logic [34:0] hex_nb;
  logic        busy_ov, done_ov, ovf_ov;
  logic [13:0] hex_ov;

  int total = 0;
  int bad   = 0;
  int lat, busy_n, nd, ndone;

  logic [34:0] b2b_exp [3];

  always #5 clk = ~clk;

  bcd_seg7_display #(.BIN_WIDTH(16), .DIGITS(5), .BLANK_LEADING(1'b1), .ALLOW_TRUNC(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in), .mode(mode),
    .busy(busy_m), .done(done_m), .overflow(ovf_m), .HEX(hex_m));

  bcd_seg7_display #(.BIN_WIDTH(16), .DIGITS(5), .BLANK_LEADING(1'b0), .ALLOW_TRUNC(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in), .mode(mode),
    .busy(busy_nb), .done(done_nb), .overflow(ovf_nb), .HEX(hex_nb));

  bcd_seg7_display #(.BIN_WIDTH(16), .DIGITS(2), .BLANK_LEADING(1'b1), .ALLOW_TRUNC(1'b1)) dut_ov (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in), .mode(mode),
    .busy(busy_ov), .done(done_ov), .overflow(ovf_ov), .HEX(hex_ov));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Edges counted from the accepting edge to the one that makes done visible; busy counted per cycle before it.
  task automatic run(input logic [15:0] v, input logic m, output int l, output int b);
    @(negedge clk);
    bin_in = v;
    mode   = m;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    l = 0;
    b = 0;
    while (l < 40) begin
      @(negedge clk);
      if (done_m) break;
      if (busy_m) b++;
      @(posedge clk);
      l++;
    end
    check("done_seen", done_m, 1);
    check("busy_at_done", busy_m, 0);
    check("done_peers", {done_nb, done_ov}, 2'b11);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    mode   = 1'b0;
    bin_in = '0;
    b2b_exp[0] = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79};
    b2b_exp[1] = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24};
    b2b_exp[2] = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hex", hex_m, {5{7'h7F}});
    check("rst_busy", busy_m, 0);
    check("rst_done", done_m, 0);
    check("rst_ovf", ovf_m, 0);
    check("rst_hex_ov", hex_ov, {2{7'h7F}});
    check("rst_peers", {busy_nb, busy_ov, ovf_nb, ovf_ov}, 4'b0000);
    reset = 1'b0;

    run(16'hFFFF, 1'b0, lat, busy_n);
    check("dec_ffff_lat", lat, 17);
    check("dec_ffff_busy", busy_n, 17);
    check("dec_ffff_hex", hex_m, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12});
    check("dec_ffff_hex_nb", hex_nb, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12});
    @(negedge clk);
    check("done_one_cycle", done_m, 0);

    run(16'd1234, 1'b0, lat, busy_n);
    check("dec_1234_hex", hex_m, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});
    check("dec_1234_hex_nb", hex_nb, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19});

    run(16'd0, 1'b0, lat, busy_n);
    check("dec_0_hex", hex_m, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    check("dec_0_hex_nb", hex_nb, {5{7'h40}});

    run(16'h00AB, 1'b1, lat, busy_n);
    check("hex_ab_lat", lat, 1);
    check("hex_ab_busy", busy_n, 1);
    check("hex_ab_hex", hex_m, {7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h03});
    check("hex_ab_ovf", ovf_m, 0);

    run(16'h01AB, 1'b1, lat, busy_n);
    check("hex_1ab_hex", hex_m, {7'h7F, 7'h7F, 7'h79, 7'h08, 7'h03});
    check("hex_1ab_ovf", ovf_m, 0);
    check("hex_1ab_hex_ov", hex_ov, {7'h08, 7'h03});
    check("hex_1ab_ovf_ov", ovf_ov, 1);
    @(negedge clk);
    check("ovf_held", ovf_ov, 1);

    run(16'd1234, 1'b0, lat, busy_n);
    check("ovf_cleared", ovf_ov, 0);
    check("dec_1234_again", hex_m, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});

    // Reset in the middle of a decimal conversion.
    @(negedge clk);
    bin_in = 16'hFFFF;
    mode   = 1'b0;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_hex", hex_m, {5{7'h7F}});
    check("midrst_busy", busy_m, 0);
    check("midrst_done", done_m, 0);
    reset = 1'b0;
    nd = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_m) nd++;
    end
    check("midrst_no_done", nd, 0);

    // Start held high; only values present on IDLE edges (every 18th) are 1, 2, 3.
    @(negedge clk);
    start  = 1'b1;
    mode   = 1'b0;
    bin_in = 16'd1;
    ndone  = 0;
    for (int k = 0; k <= 56; k++) begin
      @(posedge clk);
      #1;
      start  = ((k + 1) < 54);
      bin_in = (((k + 1) % 18) == 0) ? 16'(((k + 1) / 18) % 3 + 1) : 16'(1000 + k + 1);
      @(negedge clk);
      if (done_m) begin
        check("b2b_edge", k, 17 + 18 * ndone);
        if (ndone < 3) check("b2b_hex", hex_m, b2b_exp[ndone]);
        ndone++;
      end
    end
    check("b2b_count", ndone, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
